vram_xfer_engine: RTL and testbench

- Bus-master initiator for one port of the EpochTV1 video dual-port RAM.
- Drives the RAM's active-low nCE/nWE/nOE strobe interface and consumes its registered one-cycle read data.
- Two operations: block copy (read, capture, write per word) and block fill (constant write).
- Used for VRAM clear at boot and sprite/tile block moves. A HOLD input lets a higher-priority requester (video fetch) take the port.

---
 rtl/vram_xfer_engine.sv | 125 ++++++++++++
 tb/tb_vram_xfer_engine.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/vram_xfer_engine.sv
// Block copy / block fill bus master for one port of the EpochTV1 dual-port VRAM.
// Drives active-low nCE/nWE/nOE strobes; read data returns one cycle after a read strobe.
module vram_xfer_engine #(
   parameter int DWIDTH = 8,
   parameter int AWIDTH = 16
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              START,
   input  logic              MODE,
   input  logic [AWIDTH-1:0] SRC,
   input  logic [AWIDTH-1:0] DST,
   input  logic [AWIDTH-1:0] LEN,
   input  logic [DWIDTH-1:0] FILL,
   input  logic              HOLD,
   output logic              BUSY,
   output logic              DONE,
   output logic              nCE,
   output logic              nWE,
   output logic              nOE,
   output logic [AWIDTH-1:0] A,
   output logic [DWIDTH-1:0] DO,
   input  logic [DWIDTH-1:0] DI
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_CAP,
      S_WR,
      S_FIN
   } state_t;

   state_t              state_q, state_d;
   logic                mode_q, mode_d;
   logic [AWIDTH-1:0]   srcp_q, srcp_d;
   logic [AWIDTH-1:0]   dstp_q, dstp_d;
   logic [AWIDTH-1:0]   cnt_q, cnt_d;
   logic [DWIDTH-1:0]   data_q, data_d;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      srcp_d  = srcp_q;
      dstp_d  = dstp_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      nCE     = 1'b1;
      nWE     = 1'b1;
      nOE     = 1'b1;
      A       = '0;
      DO      = '0;

      unique case (state_q)
         S_IDLE: begin
            if (START) begin
               mode_d = MODE;
               srcp_d = SRC;
               dstp_d = DST;
               cnt_d  = LEN;
               data_d = FILL;
               if (LEN == '0)  state_d = S_FIN;
               else if (MODE)  state_d = S_WR;
               else            state_d = S_RD;
            end
         end
         S_RD: begin
            A = srcp_q;
            if (!HOLD) begin
               nCE     = 1'b0;
               nOE     = 1'b0;
               srcp_d  = srcp_q + AWIDTH'(1);
               state_d = S_CAP;
            end
         end
         S_CAP: begin
            // No access this cycle, so HOLD has nothing to yield.
            data_d  = DI;
            state_d = S_WR;
         end
         S_WR: begin
            A  = dstp_q;
            DO = data_q;
            if (!HOLD) begin
               nCE    = 1'b0;
               nWE    = 1'b0;
               dstp_d = dstp_q + AWIDTH'(1);
               cnt_d  = cnt_q - AWIDTH'(1);
               if (cnt_q == AWIDTH'(1)) state_d = S_FIN;
               else if (!mode_q)        state_d = S_RD;
            end
         end
         S_FIN: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign BUSY = (state_q != S_IDLE);
   assign DONE = (state_q == S_FIN);

   // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= S_IDLE;
         mode_q  <= 1'b0;
         srcp_q  <= '0;
         dstp_q  <= '0;
         cnt_q   <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         srcp_q  <= srcp_d;
         dstp_q  <= dstp_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
      end
   end

endmodule

// File: tb/tb_vram_xfer_engine.sv
// Directed bench for vram_xfer_engine against a behavioural RAM with registered read data.
// Expected addresses, data, latencies and strobe patterns are hand-computed constants.
module tb_vram_xfer_engine;

   localparam int DW = 8;
   localparam int AW = 16;

   logic          CLK = 1'b0;
   logic          RST;
   logic          START, MODE, HOLD;
   logic [AW-1:0] SRC, DST, LEN;
   logic [DW-1:0] FILL;
   logic          BUSY, DONE, nCE, nWE, nOE;
   logic [AW-1:0] A;
   logic [DW-1:0] DO, DI;

   int n_cmp = 0;
   int n_bad = 0;
   int wr_cnt = 0;
   int clash_cnt = 0;

   logic [DW-1:0] mem [65536];
   logic [DW-1:0] rd_q;
   logic          pk_en = 1'b0;
   logic [AW-1:0] pk_addr = '0;
   logic [DW-1:0] pk_data = '0;

   vram_xfer_engine #(.DWIDTH(DW), .AWIDTH(AW)) dut (
      .CLK(CLK), .RST(RST), .START(START), .MODE(MODE), .SRC(SRC), .DST(DST),
      .LEN(LEN), .FILL(FILL), .HOLD(HOLD), .BUSY(BUSY), .DONE(DONE),
      .nCE(nCE), .nWE(nWE), .nOE(nOE), .A(A), .DO(DO), .DI(DI)
   );

   always #5 CLK = ~CLK;

   assign DI = rd_q;

   // RAM port: synchronous write, registered read; bench preloads go through the same process.
   always @(posedge CLK) begin
      if (pk_en) mem[pk_addr] <= pk_data;
      else if (!nCE && !nWE) begin
         mem[A] <= DO;
         wr_cnt <= wr_cnt + 1;
      end
      if (!nCE && !nOE) rd_q <= mem[A];
      if (!nWE && !nOE) clash_cnt <= clash_cnt + 1;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
      @(negedge CLK);
      pk_en = 1'b1; pk_addr = a; pk_data = d;
      @(negedge CLK);
      pk_en = 1'b0;
   endtask

   // Issues START, then per cycle n after the START edge: drives HOLD, optionally re-pulses START,
   // and records a 2-bit strobe code (01 read, 10 write, 00 idle) until DONE is seen.
   task automatic run_op(input logic m, input logic [AW-1:0] s, input logic [AW-1:0] d,
                         input logic [AW-1:0] l, input logic [DW-1:0] f,
                         input int hold_n, input int restart_cyc,
                         output int lat, output logic [63:0] pat);
      lat = 0;
      pat = '0;
      @(negedge CLK);
      START = 1'b1; MODE = m; SRC = s; DST = d; LEN = l; FILL = f; HOLD = 1'b0;
      @(posedge CLK);
      for (int cyc = 1; cyc <= 200 && lat == 0; cyc++) begin
         @(negedge CLK);
         START = (cyc == restart_cyc);
         if (START) begin
            MODE = 1'b0; SRC = 16'h0010; DST = 16'h0600; LEN = 16'd1; FILL = 8'hEE;
         end
         HOLD = (cyc <= hold_n);
         #1;
         pat = {pat[61:0], (!nCE && !nOE) ? 2'b01 : (!nCE && !nWE) ? 2'b10 : 2'b00};
         if (DONE) lat = cyc;
      end
      START = 1'b0;
      HOLD  = 1'b0;
      if (lat == 0) check("done_timeout", 64'd0, 64'd1);
      @(negedge CLK);
      #1;
      check("busy_after_done", BUSY, 1'b0);
   endtask

   int          lat;
   logic [63:0] pat;
   int          wr_base;
   int          done_seen;

   initial begin
      START = 1'b0; MODE = 1'b0; HOLD = 1'b0;
      SRC = '0; DST = '0; LEN = '0; FILL = '0;
      RST = 1'b1;
      repeat (2) @(negedge CLK);
      #1;
      check("rst_strobes", {nCE, nWE, nOE}, 3'b111);
      check("rst_addr", A, 16'h0000);
      check("rst_do", DO, 8'h00);
      check("rst_busy_done", {BUSY, DONE}, 2'b00);
      @(negedge CLK);
      RST = 1'b0;

      // Fill 4 words of 0xA5 at 0x0100
      wr_base = wr_cnt;
      run_op(1'b1, 16'h0000, 16'h0100, 16'd4, 8'hA5, 0, -1, lat, pat);
      check("fill_latency", lat, 5);
      check("fill_pattern", pat, 64'h2A8);
      check("fill_writes", wr_cnt - wr_base, 4);
      for (int i = 0; i < 4; i++) check("fill_mem", mem[16'h0100 + i], 8'hA5);

      // Copy 11,22,33 from 0x0010 to 0x0200
      poke(16'h0010, 8'h11); poke(16'h0011, 8'h22); poke(16'h0012, 8'h33);
      for (int i = 0; i < 3; i++) poke(16'h0200 + i[15:0], 8'h00);
      wr_base = wr_cnt;
      run_op(1'b0, 16'h0010, 16'h0200, 16'd3, 8'h00, 0, -1, lat, pat);
      check("copy_latency", lat, 10);
      check("copy_pattern", pat, 64'h49248);
      check("copy_writes", wr_cnt - wr_base, 3);
      check("copy_mem0", mem[16'h0200], 8'h11);
      check("copy_mem1", mem[16'h0201], 8'h22);
      check("copy_mem2", mem[16'h0202], 8'h33);

      // Fill with HOLD for the first 3 cycles
      run_op(1'b1, 16'h0000, 16'h0300, 16'd2, 8'hC3, 3, -1, lat, pat);
      check("hold_latency", lat, 6);
      check("hold_pattern", pat, 64'h028);
      check("hold_mem0", mem[16'h0300], 8'hC3);
      check("hold_mem1", mem[16'h0301], 8'hC3);

      // Address wrap at the top of memory
      poke(16'hFFFE, 8'h00); poke(16'hFFFF, 8'h00); poke(16'h0000, 8'h00); poke(16'h0001, 8'h00);
      run_op(1'b1, 16'h0000, 16'hFFFE, 16'd3, 8'h5C, 0, -1, lat, pat);
      check("wrap_latency", lat, 4);
      check("wrap_fffe", mem[16'hFFFE], 8'h5C);
      check("wrap_ffff", mem[16'hFFFF], 8'h5C);
      check("wrap_0000", mem[16'h0000], 8'h5C);
      check("wrap_0001", mem[16'h0001], 8'h00);

      // Overlapping copy replicates the first source word
      poke(16'h0040, 8'h77);
      for (int i = 1; i <= 5; i++) poke(16'h0040 + i[15:0], 8'h00);
      run_op(1'b0, 16'h0040, 16'h0041, 16'd4, 8'h00, 0, -1, lat, pat);
      check("ovl_latency", lat, 13);
      for (int i = 1; i <= 4; i++) check("ovl_mem", mem[16'h0040 + i], 8'h77);
      check("ovl_mem_after", mem[16'h0045], 8'h00);

      // LEN=0 is a no-op
      wr_base = wr_cnt;
      run_op(1'b1, 16'h0000, 16'h0900, 16'd0, 8'h12, 0, -1, lat, pat);
      check("len0_latency", lat, 1);
      check("len0_pattern", pat, 64'h0);
      check("len0_writes", wr_cnt - wr_base, 0);

      // START while busy is ignored
      poke(16'h0600, 8'h00);
      wr_base = wr_cnt;
      run_op(1'b1, 16'h0000, 16'h0500, 16'd4, 8'h3C, 0, 2, lat, pat);
      check("ign_latency", lat, 5);
      check("ign_writes", wr_cnt - wr_base, 4);
      for (int i = 0; i < 4; i++) check("ign_mem", mem[16'h0500 + i], 8'h3C);
      check("ign_other", mem[16'h0600], 8'h00);

      // Reset asserted while in CAP
      poke(16'h0700, 8'h00);
      wr_base = wr_cnt;
      @(negedge CLK);
      START = 1'b1; MODE = 1'b0; SRC = 16'h0010; DST = 16'h0700; LEN = 16'd3;
      @(posedge CLK);
      @(negedge CLK);
      START = 1'b0;
      @(negedge CLK);
      RST = 1'b1;
      #1;
      check("rstmid_strobes", {nCE, nWE, nOE}, 3'b111);
      check("rstmid_busy_done", {BUSY, DONE}, 2'b00);
      repeat (2) @(negedge CLK);
      RST = 1'b0;
      done_seen = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge CLK);
         #1;
         if (DONE || BUSY) done_seen++;
      end
      check("rstmid_no_activity", done_seen, 0);
      check("rstmid_writes", wr_cnt - wr_base, 0);
      check("rstmid_mem", mem[16'h0700], 8'h00);

      run_op(1'b1, 16'h0000, 16'h0800, 16'd2, 8'h99, 0, -1, lat, pat);
      check("post_rst_latency", lat, 3);
      check("post_rst_mem0", mem[16'h0800], 8'h99);
      check("post_rst_mem1", mem[16'h0801], 8'h99);

      check("we_oe_clash", clash_cnt, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
